// File: rtl/accum4.sv
// accum4: batch accumulator for 4-bit operands. It sums N_OPS operands modulo 16, keeps a sticky
// carry-out flag for the batch, and offers the result on a valid/ready output port.
module accum4 #(
    parameter int unsigned N_OPS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_sum,
    output logic       out_carry
);

    typedef enum logic [0:0] {StAccum, StDone} state_e;

    localparam logic [3:0] LastCnt = 4'(N_OPS - 1);

    state_e     state_q, state_d;
    logic [3:0] acc_q, acc_d;
    logic       cflag_q, cflag_d;
    logic [3:0] cnt_q, cnt_d;
    logic [4:0] sum;
    logic       xfer;

    assign sum  = {1'b0, acc_q} + {1'b0, in_data};
    assign xfer = in_valid && in_ready;

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StAccum;
            acc_q   <= 4'd0;
            cflag_q <= 1'b0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cflag_q <= cflag_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and datapath update; clr wins over a same-cycle transfer
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cflag_d = cflag_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StAccum: begin
                if (clr) begin
                    acc_d   = 4'd0;
                    cflag_d = 1'b0;
                    cnt_d   = 4'd0;
                end else if (xfer) begin
                    acc_d   = sum[3:0];
                    cflag_d = cflag_q | sum[4];
                    if (cnt_q == LastCnt) begin
                        cnt_d   = 4'd0;
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            StDone: begin
                if (out_ready) begin
                    acc_d   = 4'd0;
                    cflag_d = 1'b0;
                    state_d = StAccum;
                end
            end
            default: state_d = StAccum;
        endcase
    end

    // Handshake outputs depend on state only; result comes straight from the registers
    always_comb begin
        in_ready  = (state_q == StAccum);
        out_valid = (state_q == StDone);
        out_sum   = acc_q;
        out_carry = cflag_q;
    end

endmodule

// File: tb/tb_accum4.sv
// tb_accum4: table-driven batches, directed corner sequences and a randomized run checked
// against a queue-based reference model of accum4.
module tb_accum4;

    localparam int unsigned NOps = 4;

    logic       clk = 1'b0;
    logic       rst, clr, in_valid, out_ready;
    logic [3:0] in_data;
    logic       in_ready, out_valid, out_carry;
    logic [3:0] out_sum;

    int total = 0;
    int bad   = 0;

    accum4 #(.N_OPS(NOps)) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_carry(out_carry)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] ops [4];
        logic [3:0] sum;
        logic       carry;
    } vec_t;

    vec_t vecs [6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Sends four operands back-to-back; result is checked the cycle after the last accept.
    task automatic run_batch(input logic [3:0] o0, input logic [3:0] o1, input logic [3:0] o2,
                             input logic [3:0] o3, input logic [3:0] es, input logic ec,
                             input logic rdy);
        logic [3:0] ops [4];
        ops[0] = o0; ops[1] = o1; ops[2] = o2; ops[3] = o3;
        out_ready = rdy;
        for (int i = 0; i < 4; i++) begin
            chk("in_ready_accum", {3'd0, in_ready}, 4'd1);
            in_valid = 1'b1;
            in_data  = ops[i];
            step();
        end
        in_valid = 1'b0;
        chk("out_valid_done", {3'd0, out_valid}, 4'd1);
        chk("out_sum", out_sum, es);
        chk("out_carry", {3'd0, out_carry}, {3'd0, ec});
        chk("in_ready_done", {3'd0, in_ready}, 4'd0);
        if (rdy) begin
            step();
            chk("out_valid_drop", {3'd0, out_valid}, 4'd0);
            chk("in_ready_back", {3'd0, in_ready}, 4'd1);
        end
    endtask

    // Reference model: a batch is a list of accepted operands; the result is their plain
    // integer sum mod 16, and some addition carried iff that sum reached 16.
    logic [3:0] mq [$];
    bit         m_pend;
    int         m_sum;

    initial begin
        vecs[0] = '{ops: '{4'h3, 4'h5, 4'h2, 4'h1}, sum: 4'hB, carry: 1'b0};
        vecs[1] = '{ops: '{4'hF, 4'h1, 4'h0, 4'h0}, sum: 4'h0, carry: 1'b1};
        vecs[2] = '{ops: '{4'h1, 4'h1, 4'h1, 4'h1}, sum: 4'h4, carry: 1'b0};
        vecs[3] = '{ops: '{4'hF, 4'hF, 4'hF, 4'hF}, sum: 4'hC, carry: 1'b1};
        vecs[4] = '{ops: '{4'h7, 4'h8, 4'h0, 4'h0}, sum: 4'hF, carry: 1'b0};
        vecs[5] = '{ops: '{4'h0, 4'h0, 4'h0, 4'h0}, sum: 4'h0, carry: 1'b0};

        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_data = 4'h0;
        step();
        step();
        rst = 1'b0;
        chk("rst_in_ready", {3'd0, in_ready}, 4'd1);
        chk("rst_out_valid", {3'd0, out_valid}, 4'd0);
        chk("rst_out_sum", out_sum, 4'h0);
        chk("rst_out_carry", {3'd0, out_carry}, 4'd0);

        foreach (vecs[i])
            run_batch(vecs[i].ops[0], vecs[i].ops[1], vecs[i].ops[2], vecs[i].ops[3],
                      vecs[i].sum, vecs[i].carry, 1'b1);

        // Backpressure: result holds, in_ready stays low, offered operands are ignored
        run_batch(4'h8, 4'h8, 4'h8, 4'h8, 4'h0, 1'b1, 1'b0);
        in_valid = 1'b1;
        in_data  = 4'h3;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_out_valid", {3'd0, out_valid}, 4'd1);
            chk("bp_out_sum", out_sum, 4'h0);
            chk("bp_out_carry", {3'd0, out_carry}, 4'd1);
            chk("bp_in_ready", {3'd0, in_ready}, 4'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_release", {3'd0, out_valid}, 4'd0);
        run_batch(4'h1, 4'h1, 4'h1, 4'h1, 4'h4, 1'b0, 1'b1);

        // Idle gaps between operands
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_data  = 4'(i);
            step();
            in_valid = 1'b0;
            if (i < 4) begin
                step();
                chk("gap_no_valid", {3'd0, out_valid}, 4'd0);
                step();
            end
        end
        chk("gap_out_valid", {3'd0, out_valid}, 4'd1);
        chk("gap_out_sum", out_sum, 4'hA);
        chk("gap_out_carry", {3'd0, out_carry}, 4'd0);
        step();

        // Reset mid-batch
        in_valid = 1'b1;
        in_data  = 4'h7;
        step();
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_out_valid", {3'd0, out_valid}, 4'd0);
        chk("mrst_out_sum", out_sum, 4'h0);
        chk("mrst_out_carry", {3'd0, out_carry}, 4'd0);
        chk("mrst_in_ready", {3'd0, in_ready}, 4'd1);
        run_batch(4'h1, 4'h1, 4'h1, 4'h1, 4'h4, 1'b0, 1'b1);

        // clr in ACCUM drops the partial batch and the same-cycle operand
        in_valid = 1'b1;
        in_data  = 4'h9;
        step();
        step();
        clr     = 1'b1;
        in_data = 4'h5;
        step();
        clr      = 1'b0;
        in_valid = 1'b0;
        chk("clr_acc", out_sum, 4'h0);
        run_batch(4'h2, 4'h2, 4'h2, 4'h2, 4'h8, 1'b0, 1'b1);

        // clr in DONE is ignored
        run_batch(4'h3, 4'h3, 4'h3, 4'h3, 4'hC, 1'b0, 1'b0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_done_valid", {3'd0, out_valid}, 4'd1);
        chk("clr_done_sum", out_sum, 4'hC);
        out_ready = 1'b1;
        step();

        // Reset in DONE
        run_batch(4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 1'b1, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("drst_out_valid", {3'd0, out_valid}, 4'd0);
        chk("drst_out_carry", {3'd0, out_carry}, 4'd0);

        // Randomized traffic against the reference model
        mq.delete();
        m_pend = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            chk("rnd_out_valid", {3'd0, out_valid}, {3'd0, m_pend});
            chk("rnd_in_ready", {3'd0, in_ready}, {3'd0, !m_pend});
            if (m_pend) begin
                chk("rnd_out_sum", out_sum, 4'(m_sum % 16));
                chk("rnd_out_carry", {3'd0, out_carry}, {3'd0, m_sum >= 16});
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 2) != 0);
            clr       = ($urandom_range(0, 15) == 0);
            if (!m_pend) begin
                if (clr) begin
                    mq.delete();
                end else if (in_valid) begin
                    mq.push_back(in_data);
                    if (mq.size() == NOps) begin
                        m_sum = 0;
                        foreach (mq[k]) m_sum += int'(mq[k]);
                        m_pend = 1'b1;
                        mq.delete();
                    end
                end
            end else if (out_ready) begin
                m_pend = 1'b0;
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
